// File: rtl/cpu_pkg.sv
// Shared encodings and vector defaults for the fetch-side PC logic.
package cpu_pkg;

  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_JMP = 2'b10;
  localparam logic [1:0] PC_JR  = 2'b11;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] ILLOP_DEF    = 32'h8000_0004;
  localparam logic [31:0] XADR_DEF     = 32'h8000_0008;

  function automatic int idw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/irq_pending.sv
// Interrupt edge capture, pending latch and lowest-index-wins selection.
module irq_pending
  import cpu_pkg::*;
#(
  parameter int NUM_IRQ = 4,
  parameter int IDW     = idw(NUM_IRQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic [NUM_IRQ-1:0] irq_mask,
  input  logic               take,
  output logic               any_cand,
  output logic [IDW-1:0]     win_id
);

  logic [NUM_IRQ-1:0] irq_q, irq_d;
  logic [NUM_IRQ-1:0] pend_q, pend_d;
  logic [NUM_IRQ-1:0] cand, clr, rise;

  assign cand = pend_q & ~irq_mask;
  assign rise = irq & ~irq_q;

  always_comb begin
    any_cand = 1'b0;
    win_id   = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (cand[i]) begin
        any_cand = 1'b1;
        win_id   = IDW'(i);
      end
    end
  end

  // A fresh edge on the channel being serviced must survive the clear.
  always_comb begin
    irq_d  = irq;
    clr    = take ? (NUM_IRQ'(1) << win_id) : '0;
    pend_d = (pend_q & ~clr) | rise;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_q  <= '0;
      pend_q <= '0;
    end else begin
      irq_q  <= irq_d;
      pend_q <= pend_d;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC selection with exception/interrupt entry and supervisor-bit protection.
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              NUM_IRQ  = 4,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF),
  parameter logic [XLEN-1:0] ILLOP    = XLEN'(ILLOP_DEF),
  parameter logic [XLEN-1:0] XADR     = XLEN'(XADR_DEF),
  localparam int             IDW      = idw(NUM_IRQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic [1:0]         pc_src,
  input  logic [XLEN-1:0]    con_ba,
  input  logic [XLEN-1:0]    jt,
  input  logic [XLEN-1:0]    jr_target,
  input  logic               undef,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic [NUM_IRQ-1:0] irq_mask,
  output logic [XLEN-1:0]    pc,
  output logic [XLEN-1:0]    pc_plus4,
  output logic [XLEN-1:0]    epc,
  output logic               supervisor,
  output logic               irq_taken,
  output logic [IDW-1:0]     irq_id
);

  localparam logic [XLEN-1:0] MSB = {1'b1, {(XLEN-1){1'b0}}};

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic            irq_taken_q, irq_taken_d;
  logic [IDW-1:0]  irq_id_q, irq_id_d;
  logic            take, any_cand;
  logic [IDW-1:0]  win_id;

  function automatic logic [XLEN-1:0] with_msb(input logic [XLEN-1:0] v, input logic b);
    return (v & ~MSB) | (b ? MSB : '0);
  endfunction

  assign pc         = pc_q;
  assign epc        = epc_q;
  assign irq_taken  = irq_taken_q;
  assign irq_id     = irq_id_q;
  assign pc_plus4   = pc_q + XLEN'(4);
  assign supervisor = pc_q[XLEN-1];

  irq_pending #(.NUM_IRQ(NUM_IRQ), .IDW(IDW)) u_pend (
    .clk      (clk),
    .reset    (reset),
    .irq      (irq),
    .irq_mask (irq_mask),
    .take     (take),
    .any_cand (any_cand),
    .win_id   (win_id)
  );

  always_comb begin
    pc_d        = pc_q;
    epc_d       = epc_q;
    irq_taken_d = 1'b0;
    irq_id_d    = irq_id_q;
    take        = 1'b0;
    if (!stall) begin
      if (undef) begin
        pc_d  = XADR;
        epc_d = pc_plus4;
      end else if (!supervisor && any_cand) begin
        // Interrupted instruction is re-executed on return, so save pc itself.
        take        = 1'b1;
        pc_d        = ILLOP;
        epc_d       = pc_q;
        irq_taken_d = 1'b1;
        irq_id_d    = win_id;
      end else begin
        unique case (pc_src)
          PC_SEQ:  pc_d = pc_plus4;
          PC_BR:   pc_d = with_msb(con_ba, supervisor);
          PC_JMP:  pc_d = with_msb(jt, supervisor);
          PC_JR:   pc_d = with_msb(jr_target, jr_target[XLEN-1] & supervisor);
          default: pc_d = pc_plus4;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q        <= RESET_PC;
      epc_q       <= '0;
      irq_taken_q <= 1'b0;
      irq_id_q    <= '0;
    end else begin
      pc_q        <= pc_d;
      epc_q       <= epc_d;
      irq_taken_q <= irq_taken_d;
      irq_id_q    <= irq_id_d;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed scenarios plus randomized traffic checked against a behavioural model.
module tb_pc_sequencer;

  localparam logic [31:0] ILLOP_V = 32'h8000_0004;
  localparam logic [31:0] XADR_V  = 32'h8000_0008;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, undef;
  logic [1:0]  pc_src;
  logic [31:0] con_ba, jt, jr_target;
  logic [3:0]  irq, irq_mask;
  logic [31:0] pc, pc_plus4, epc;
  logic        supervisor, irq_taken;
  logic [1:0]  irq_id;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // behavioural model state
  logic [31:0] m_pc, m_epc;
  logic [3:0]  m_pend, m_prev, m_rise, m_cand;
  logic        m_taken;
  logic [1:0]  m_id;
  int          m_w;

  pc_sequencer dut (
    .clk(clk), .reset(reset), .stall(stall), .pc_src(pc_src),
    .con_ba(con_ba), .jt(jt), .jr_target(jr_target), .undef(undef),
    .irq(irq), .irq_mask(irq_mask), .pc(pc), .pc_plus4(pc_plus4),
    .epc(epc), .supervisor(supervisor), .irq_taken(irq_taken), .irq_id(irq_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: the user-visible rules, one clock at a time.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_pc = 32'h0; m_epc = 32'h0; m_pend = 4'h0; m_prev = 4'h0;
      m_taken = 1'b0; m_id = 2'd0;
    end else begin
      m_rise  = irq & ~m_prev;
      m_prev  = irq;
      m_taken = 1'b0;
      m_cand  = m_pend & ~irq_mask;
      if (stall) begin
        m_pend = m_pend | m_rise;
      end else if (undef) begin
        m_epc  = m_pc + 32'd4;
        m_pc   = XADR_V;
        m_pend = m_pend | m_rise;
      end else if (!m_pc[31] && m_cand != 4'h0) begin
        m_w = 0;
        while (!m_cand[m_w]) m_w++;
        m_pend[m_w] = 1'b0;
        m_pend  = m_pend | m_rise;
        m_epc   = m_pc;
        m_pc    = ILLOP_V;
        m_taken = 1'b1;
        m_id    = 2'(m_w);
      end else begin
        m_pend = m_pend | m_rise;
        case (pc_src)
          2'd0: m_pc = m_pc + 32'd4;
          2'd1: m_pc = {m_pc[31], con_ba[30:0]};
          2'd2: m_pc = {m_pc[31], jt[30:0]};
          default: m_pc = {m_pc[31] & jr_target[31], jr_target[30:0]};
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en && reset) begin
      chk("pc", pc, m_pc);
      chk("epc", epc, m_epc);
      chk("pc_plus4", pc_plus4, m_pc + 32'd4);
      chk("supervisor", {31'd0, supervisor}, {31'd0, m_pc[31]});
      chk("irq_taken", {31'd0, irq_taken}, {31'd0, m_taken});
      chk("irq_id", {30'd0, irq_id}, {30'd0, m_id});
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic entry(input string nm, input logic [31:0] e_epc, input logic [1:0] e_id);
    chk({nm, "_pc"}, pc, ILLOP_V);
    chk({nm, "_epc"}, epc, e_epc);
    chk({nm, "_id"}, {30'd0, irq_id}, {30'd0, e_id});
    chk({nm, "_taken"}, {31'd0, irq_taken}, 32'd1);
  endtask

  initial begin
    reset = 1'b0; stall = 1'b0; undef = 1'b0; pc_src = 2'd0;
    con_ba = '0; jt = '0; jr_target = '0; irq = '0; irq_mask = '0;
    cyc(2);
    chk("rst_pc", pc, 32'h0);
    chk("rst_epc", epc, 32'h0);
    chk("rst_taken", {31'd0, irq_taken}, 32'd0);
    chk("rst_id", {30'd0, irq_id}, 32'd0);
    reset = 1'b1;
    chk_en = 1'b1;

    // sequential fetch after reset
    cyc(); chk("seq1", pc, 32'h4);
    cyc(); chk("seq2", pc, 32'h8);
    cyc(); chk("seq3", pc, 32'hC);
    chk("seq_taken", {31'd0, irq_taken}, 32'd0);

    // two simultaneous edges, lowest channel first
    irq = 4'b0110;
    cyc(); chk("pre_entry_pc", pc, 32'h10);
    cyc(); entry("irq1", 32'h10, 2'd1);
    pc_src = 2'd3; jr_target = 32'h10;
    cyc(); chk("ret_pc", pc, 32'h10);
    chk("taken_pulse", {31'd0, irq_taken}, 32'd0);
    pc_src = 2'd0;
    cyc(); entry("irq2", 32'h10, 2'd2);

    // supervisor blocks entry until return to user
    irq = 4'b0000; pc_src = 2'd2; jt = 32'h20;
    cyc(); chk("sup_jmp", pc, 32'h8000_0020);
    irq = 4'b0001; pc_src = 2'd1; con_ba = 32'h20;
    cyc(2); chk("sup_hold", pc, 32'h8000_0020);
    chk("sup_no_taken", {31'd0, irq_taken}, 32'd0);
    pc_src = 2'd3; jr_target = 32'h40;
    cyc(); chk("sup_ret", pc, 32'h40);
    pc_src = 2'd0;
    cyc(); entry("irq0", 32'h40, 2'd0);

    // exception outranks a pending interrupt and leaves it pending
    irq = 4'b0010; irq_mask = 4'hF; jr_target = 32'h30; pc_src = 2'd3;
    cyc(); chk("masked_user", pc, 32'h30);
    irq_mask = 4'h0; undef = 1'b1;
    cyc(); chk("exc_pc", pc, XADR_V); chk("exc_epc", epc, 32'h34);
    undef = 1'b0; jr_target = 32'h50;
    cyc(); chk("exc_ret", pc, 32'h50);
    pc_src = 2'd0;
    cyc(); entry("kept", 32'h50, 2'd1);

    // user jr cannot set MSB; stall defers entry
    irq = 4'b0000; jr_target = 32'h200; pc_src = 2'd3;
    cyc(); chk("jr_user", pc, 32'h200);
    jr_target = 32'h8000_0100;
    cyc(); chk("jr_msb_strip", pc, 32'h100);
    stall = 1'b1; irq = 4'b1000;
    cyc(3); chk("stall_pc", pc, 32'h100);
    chk("stall_taken", {31'd0, irq_taken}, 32'd0);
    stall = 1'b0; pc_src = 2'd0;
    cyc(); entry("irq3", 32'h100, 2'd3);

    // masked pending discarded by reset
    irq = 4'b0000; irq_mask = 4'b1000; jr_target = 32'h60; pc_src = 2'd3;
    cyc(); chk("jr60", pc, 32'h60);
    irq = 4'b1000; pc_src = 2'd0;
    cyc(2); chk("mask_pc", pc, 32'h68);
    chk("mask_taken", {31'd0, irq_taken}, 32'd0);
    irq_mask = 4'h0;
    #2 reset = 1'b0; irq = 4'b0000;
    #1 chk("arst_pc", pc, 32'h0); chk("arst_epc", epc, 32'h0);
    chk("arst_id", {30'd0, irq_id}, 32'd0);
    cyc(); reset = 1'b1;
    cyc(); chk("post_rst1", pc, 32'h4);
    cyc(); chk("post_rst2", pc, 32'h8);
    chk("discard", {31'd0, irq_taken}, 32'd0);

    // level held high across reset release counts as an edge
    cyc(); #2 reset = 1'b0; irq = 4'b0001;
    cyc(); reset = 1'b1;
    cyc(); chk("held_pc", pc, 32'h4);
    cyc(); entry("held", 32'h4, 2'd0);

    // randomized traffic, checked every cycle by the compare process
    for (int k = 0; k < 3000; k++) begin
      stall     = ($urandom_range(7) == 0);
      undef     = ($urandom_range(19) == 0);
      pc_src    = 2'($urandom_range(3));
      con_ba    = $urandom;
      jt        = $urandom;
      jr_target = $urandom;
      for (int b = 0; b < 4; b++)
        if ($urandom_range(5) == 0) irq[b] = ~irq[b];
      if ($urandom_range(15) == 0) irq_mask = 4'($urandom);
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
